mux_tree_arbiter: RTL and testbench



---
 rtl/mux_tree_arbiter.sv | 88 ++++++++
 tb/tb_mux_tree_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_arbiter.sv
// Round-robin arbiter driving the registered select lines of a shared mux tree.
// Holds each grant for a whole packet, with zero-bubble handover and a beat cap.
module mux_tree_arbiter #(
  parameter int N_REQ     = 4,
  parameter int SEL_W     = 2,
  parameter int MAX_BEATS = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_REQ-1:0] REQ,
  input  logic [N_REQ-1:0] LAST,
  input  logic             OUT_READY,
  output logic [N_REQ-1:0] GNT,
  output logic [SEL_W-1:0] SEL,
  output logic             OUT_VALID,
  output logic             BUSY,
  output logic             OVERRUN
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BEATS);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] win_idx;
  logic [SEL_W-1:0] cand;
  logic [7:0]       beat_cnt;
  logic             found;
  logic             beat;
  logic             cap_hit;
  logic             end_grant;
  logic             arb;

  always_comb begin
    beat      = BUSY & REQ[SEL] & OUT_READY;
    cap_hit   = (beat_cnt + 8'd1) == MAX_CNT;
    end_grant = beat & (LAST[SEL] | cap_hit);
    arb       = (state == IDLE) | end_grant;
    OUT_VALID = BUSY & REQ[SEL];
  end

  // Search ptr+1 .. ptr+N_REQ; the last candidate is the current owner itself,
  // so it only wins again when nobody else is requesting.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && REQ[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      GNT      <= '0;
      SEL      <= '0;
      BUSY     <= 1'b0;
      OVERRUN  <= 1'b0;
      ptr      <= SEL_W'(N_REQ - 1);
      beat_cnt <= '0;
    end else begin
      OVERRUN <= end_grant & cap_hit & ~LAST[SEL];
      if (arb) begin
        if (found) begin
          state    <= GRANT;
          BUSY     <= 1'b1;
          GNT      <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          SEL      <= win_idx;
          ptr      <= win_idx;
          beat_cnt <= '0;
        end else begin
          state <= IDLE;
          BUSY  <= 1'b0;
          GNT   <= '0;
        end
      end else if (beat && beat_cnt != MAX_CNT) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mux_tree_arbiter.sv
// Scoreboard bench for mux_tree_arbiter: a packet-level model predicts each cycle's
// registered outputs, a negedge monitor pops and compares them against the DUT.
module tb_mux_tree_arbiter;

  localparam int N   = 4;
  localparam int MAX = 16;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [N-1:0] REQ;
  logic [N-1:0] LAST;
  logic         OUT_READY;
  logic [N-1:0] GNT;
  logic [1:0]   SEL;
  logic         OUT_VALID;
  logic         BUSY;
  logic         OVERRUN;

  mux_tree_arbiter #(.N_REQ(N), .SEL_W(2), .MAX_BEATS(MAX)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .LAST(LAST), .OUT_READY(OUT_READY),
    .GNT(GNT), .SEL(SEL), .OUT_VALID(OUT_VALID), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0] gnt;
    logic [1:0]   sel;
    logic         busy;
    logic         ovr;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Reference model: who owns the path, the rotation pointer, beats so far.
  int owner;
  int mptr;
  int mcnt;
  int msel;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    mptr  = N - 1;
    mcnt  = 0;
    msel  = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rd);
    exp_t e;
    bit   ovr = 0;
    bit   do_arb = (owner < 0);
    if (owner >= 0 && r[owner] && rd) begin
      mcnt++;
      if (l[owner]) do_arb = 1;
      else if (mcnt == MAX) begin
        do_arb = 1;
        ovr    = 1;
      end
    end
    if (do_arb) begin
      owner = -1;
      for (int k = 1; k <= N; k++) begin
        int c = (mptr + k) % N;
        if (r[c]) begin
          owner = c;
          mptr  = c;
          msel  = c;
          mcnt  = 0;
          break;
        end
      end
    end
    e.gnt  = (owner >= 0) ? N'(1 << owner) : '0;
    e.sel  = 2'(msel);
    e.busy = (owner >= 0);
    e.ovr  = ovr;
    sbq.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rd);
    REQ = r;
    LAST = l;
    OUT_READY = rd;
    @(posedge CLK);
    #1;
    model_step(r, l, rd);
  endtask

  // Assert reset between edges and check that outputs clear without a clock.
  task automatic mid_reset();
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_gnt", int'(GNT), 0);
    chk("rst_sel", int'(SEL), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_ovr", int'(OVERRUN), 0);
    model_reset();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("gnt", int'(GNT), int'(e.gnt));
      chk("sel", int'(SEL), int'(e.sel));
      chk("busy", int'(BUSY), int'(e.busy));
      chk("overrun", int'(OVERRUN), int'(e.ovr));
      chk("out_valid", int'(OUT_VALID), int'(e.busy & REQ[e.sel]));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    REQ = '0;
    LAST = '0;
    OUT_READY = 1'b0;
    model_reset();
    #12;
    chk("por_gnt", int'(GNT), 0);
    chk("por_sel", int'(SEL), 0);
    chk("por_busy", int'(BUSY), 0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Idle cycles, then round-robin with single-beat packets
    repeat (2) step(4'b0000, 4'b0000, 1'b1);
    repeat (6) step(4'b1111, 4'b1111, 1'b1);

    // Packet lock: requester 2 sends 4 beats while requester 0 waits
    mid_reset();
    step(4'b0100, 4'b0000, 1'b1);
    repeat (3) step(4'b0101, 4'b0000, 1'b1);
    step(4'b0101, 4'b0100, 1'b1);
    step(4'b0001, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);

    // Backpressure on a 2-beat packet from requester 1, then a locked gap
    mid_reset();
    step(4'b0010, 4'b0000, 1'b1);
    repeat (3) step(4'b0010, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 1'b1);
    step(4'b0010, 4'b0010, 1'b1);
    repeat (2) step(4'b0000, 4'b0000, 1'b1);

    // Forced release after MAX beats, with a stall inside the stream
    mid_reset();
    step(4'b1000, 4'b0000, 1'b1);
    repeat (5) step(4'b1010, 4'b0000, 1'b1);
    step(4'b1010, 4'b0000, 1'b0);
    repeat (11) step(4'b1010, 4'b0000, 1'b1);
    repeat (2) step(4'b0010, 4'b0010, 1'b1);

    // LAST coinciding with the cap is a plain release
    mid_reset();
    step(4'b0001, 4'b0000, 1'b1);
    repeat (MAX - 1) step(4'b0011, 4'b0000, 1'b1);
    step(4'b0011, 4'b0001, 1'b1);
    step(4'b0011, 4'b0000, 1'b1);

    // Single requester keeps being re-granted
    mid_reset();
    repeat (4) step(4'b0100, 4'b0100, 1'b1);
    repeat (2) step(4'b0000, 4'b0000, 1'b1);

    // Reset in the middle of a packet from requester 3
    mid_reset();
    repeat (3) step(4'b1000, 4'b0000, 1'b1);
    mid_reset();
    repeat (3) step(4'b1010, 4'b1010, 1'b1);

    // Randomized traffic: dense LAST, then sparse LAST to reach the cap
    mid_reset();
    repeat (1500) step(4'($urandom_range(0, 15)), 4'($urandom & $urandom),
                       1'($urandom_range(0, 3) != 0));
    repeat (1500) step(4'($urandom_range(0, 15)),
                       ($urandom_range(0, 19) == 0) ? 4'hF : 4'h0,
                       1'($urandom_range(0, 7) != 0));

    @(negedge CLK);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
